spi_config_master: RTL and testbench

- Two-requester write sequencer for the on-chip SPI configuration register file (registers 0..4: output enables, PWM enables, PWM duty cycle).
- Arbitrates register-write requests round-robin and serialises each accepted request as one 16-bit SPI mode-0 frame on SCLK/COPI/nCS.
- Frame format: bit15 = 1 (write), bits 14:8 = address, bits 7:0 = data; sent MSB first.
- Sits between firmware/test logic and the peripheral's SPI pins.

---
 rtl/spi_config_master_pkg.sv | 30 +++
 rtl/spi_config_master_if.sv | 11 +
 rtl/spi_frame_shifter.sv | 119 +++++++++++
 rtl/spi_config_master.sv | 77 +++++++
 tb/tb_spi_config_master.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_config_master_pkg.sv
// rtl/spi_config_master_pkg.sv - shared types and frame layout for the SPI config write sequencer
package spi_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    localparam int       FRAME_W    = 16;
    localparam int       ADDR_W     = 7;
    localparam int       DATA_W     = 8;
    localparam logic     WRITE_FLAG = 1'b1;
    localparam int       WR_BIT     = 15;
    localparam int       ADDR_MSB   = 14;
    localparam int       ADDR_LSB   = 8;

    function automatic logic [FRAME_W-1:0] make_frame(input logic [ADDR_W-1:0] addr,
                                                      input logic [DATA_W-1:0] data);
        logic [FRAME_W-1:0] f;
        f                    = '0;
        f[WR_BIT]            = WRITE_FLAG;
        f[ADDR_MSB:ADDR_LSB] = addr;
        f[ADDR_LSB-1:0]      = data;
        return f;
    endfunction

endpackage

// File: rtl/spi_config_master_if.sv
// rtl/spi_config_master_if.sv - register-write request handshake between a requester and the sequencer
interface spi_cfg_req_if;
    logic                             valid;
    logic [spi_cfg_pkg::ADDR_W-1:0]   addr;
    logic [spi_cfg_pkg::DATA_W-1:0]   data;
    logic                             ready;
    logic                             err;

    modport master (output valid, output addr, output data, input ready, input err);
    modport slave  (input valid, input addr, input data, output ready, output err);
endinterface

// File: rtl/spi_frame_shifter.sv
// rtl/spi_frame_shifter.sv - serialises one 16-bit mode-0 frame with nCS setup/hold and inter-frame gap
module spi_frame_shifter
    import spi_cfg_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    output logic               done,
    output logic               sclk,
    output logic               copi,
    output logic               ncs
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] GAP_LAST = 5'(CS_GAP - 1);
    localparam logic [4:0] EDGES    = 5'd16;

    state_t             state_q, state_d;
    logic [7:0]         div_q, div_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [FRAME_W-1:0] sh_q, sh_d;
    logic               sclk_q, sclk_d;
    logic               ncs_q, ncs_d;
    logic               tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            sclk_q  <= 1'b0;
            ncs_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            sclk_q  <= sclk_d;
            ncs_q   <= ncs_d;
        end
    end

    // cnt_q counts SCLK rising edges in SHIFT and CLK_DIV-sized units in GAP
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        sclk_d  = sclk_q;
        ncs_d   = ncs_q;
        done    = 1'b0;
        tick    = (div_q == DIV_LAST);
        if (state_q != IDLE) begin
            div_d = tick ? 8'd0 : div_q + 8'd1;
        end
        case (state_q)
            IDLE: begin
                div_d = '0;
                cnt_d = '0;
                if (start) begin
                    sh_d    = frame;
                    ncs_d   = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    cnt_d   = 5'd1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        if (cnt_q != EDGES) begin
                            sh_d = {sh_q[FRAME_W-2:0], 1'b0};
                        end
                    end else if (cnt_q == EDGES) begin
                        state_d = HOLD;
                    end else begin
                        sclk_d = 1'b1;
                        cnt_d  = cnt_q + 5'd1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    ncs_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    if (cnt_q == GAP_LAST) begin
                        done    = 1'b1;
                        sh_d    = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sclk = sclk_q;
    assign copi = sh_q[FRAME_W-1];
    assign ncs  = ncs_q;

endmodule

// File: rtl/spi_config_master.sv
// rtl/spi_config_master.sv - round-robin arbiter and range check feeding the SPI frame shifter
module spi_config_master
    import spi_cfg_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int MAX_ADDR = 4,
    parameter int CS_GAP   = 2
) (
    input  logic           clk,
    input  logic           rst,
    spi_cfg_req_if.slave   req0,
    spi_cfg_req_if.slave   req1,
    output logic           busy,
    output logic           done,
    output logic           SCLK,
    output logic           COPI,
    output logic           nCS
);

    logic              busy_q, busy_d;
    logic              last_q, last_d;
    logic              grant0, grant1, bad_addr, start, shift_done;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            last_q <= 1'b1;
        end else begin
            busy_q <= busy_d;
            last_q <= last_d;
        end
    end

    // last_q=1 means requester 1 was granted last, so requester 0 wins a tie
    always_comb begin
        grant0   = !busy_q && req0.valid && (!req1.valid || last_q);
        grant1   = !busy_q && req1.valid && !grant0;
        sel_addr = grant1 ? req1.addr : req0.addr;
        sel_data = grant1 ? req1.data : req0.data;
        bad_addr = (sel_addr > ADDR_W'(MAX_ADDR));
        start    = (grant0 || grant1) && !bad_addr;
        last_d   = last_q;
        if (grant0 || grant1) begin
            last_d = grant1;
        end
        busy_d = busy_q;
        if (start) begin
            busy_d = 1'b1;
        end else if (shift_done) begin
            busy_d = 1'b0;
        end
    end

    assign req0.ready = grant0;
    assign req0.err   = grant0 && bad_addr;
    assign req1.ready = grant1;
    assign req1.err   = grant1 && bad_addr;
    assign busy       = busy_q;
    assign done       = shift_done;

    spi_frame_shifter #(
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .frame (make_frame(sel_addr, sel_data)),
        .done  (shift_done),
        .sclk  (SCLK),
        .copi  (COPI),
        .ncs   (nCS)
    );

endmodule

// File: tb/tb_spi_config_master.sv
// tb/tb_spi_config_master.sv - self-checking bench for spi_config_master
module tb_spi_config_master;

    localparam int CLK_DIV  = 4;
    localparam int CS_GAP   = 2;
    localparam int MAX_ADDR = 4;
    localparam int LOW_CYC  = 34 * CLK_DIV;
    localparam int GAP_CYC  = CS_GAP * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, done, sclk, copi, ncs;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    spi_cfg_req_if r0 ();
    spi_cfg_req_if r1 ();

    spi_config_master #(
        .CLK_DIV  (CLK_DIV),
        .MAX_ADDR (MAX_ADDR),
        .CS_GAP   (CS_GAP)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (r0),
        .req1 (r1),
        .busy (busy),
        .done (done),
        .SCLK (sclk),
        .COPI (copi),
        .nCS  (ncs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Pin-level observer: reconstructs frames as a SPI target would see them
    logic [15:0] fr_bits[$];
    int          fr_edges[$], fr_low[$], fr_first[$], fr_last[$];
    int          gnt_id[$], gnt_err[$], gnt_cyc[$], done_cyc[$];
    logic [15:0] mon_bits;
    int          mon_edges, mon_low, mon_first, mon_last;
    bit          in_frame, sclk_prev;

    always @(negedge clk) begin
        if (rst) begin
            in_frame  = 1'b0;
            mon_edges = 0;
            sclk_prev = 1'b0;
        end else begin
            if (!ncs) begin
                if (!in_frame) begin
                    in_frame  = 1'b1;
                    mon_edges = 0;
                    mon_low   = 0;
                    mon_bits  = '0;
                    mon_first = cyc;
                end
                mon_low++;
                mon_last = cyc;
                if (sclk && !sclk_prev) begin
                    mon_bits = {mon_bits[14:0], copi};
                    mon_edges++;
                end
            end else if (in_frame) begin
                in_frame = 1'b0;
                fr_bits.push_back(mon_bits);
                fr_edges.push_back(mon_edges);
                fr_low.push_back(mon_low);
                fr_first.push_back(mon_first);
                fr_last.push_back(mon_last);
            end
            sclk_prev = sclk;
            if (done) done_cyc.push_back(cyc);
            if (r0.ready) begin gnt_id.push_back(0); gnt_err.push_back(int'(r0.err)); gnt_cyc.push_back(cyc); end
            if (r1.ready) begin gnt_id.push_back(1); gnt_err.push_back(int'(r1.err)); gnt_cyc.push_back(cyc); end
        end
    end

    task automatic clr();
        fr_bits.delete(); fr_edges.delete(); fr_low.delete(); fr_first.delete(); fr_last.delete();
        gnt_id.delete(); gnt_err.delete(); gnt_cyc.delete(); done_cyc.delete();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic issue(input int id, input logic [6:0] a, input logic [7:0] d);
        bit got = 0;
        @(posedge clk); #1;
        if (id == 0) begin r0.valid = 1; r0.addr = a; r0.data = d; end
        else         begin r1.valid = 1; r1.addr = a; r1.data = d; end
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if ((id == 0) ? r0.ready : r1.ready) got = 1;
            else begin @(posedge clk); #1; end
        end
        if (!got) begin checks++; errors++; $display("FAIL issue_timeout: req%0d ready never seen, required 1", id); end
        @(posedge clk); #1;
        if (id == 0) r0.valid = 0; else r1.valid = 0;
    endtask

    task automatic wait_grant(output int id);
        bit got = 0;
        id = -1;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (r0.ready || r1.ready) begin got = 1; id = r1.ready ? 1 : 0; end
        end
        if (!got) begin checks++; errors++; $display("FAIL grant_timeout: no ready seen, required one"); end
    endtask

    task automatic wait_done();
        bit got = 0;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        if (!got) begin checks++; errors++; $display("FAIL done_timeout: done never seen, required 1"); end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic pop_frame(output logic [15:0] bits, output int edges, output int low,
                             output int first, output int last);
        bits = 'x; edges = -1; low = -1; first = -1; last = -1;
        if (fr_bits.size() > 0) begin
            bits = fr_bits.pop_front(); edges = fr_edges.pop_front(); low = fr_low.pop_front();
            first = fr_first.pop_front(); last = fr_last.pop_front();
        end
    endtask

    task automatic test_reset();
        r0.valid = 0; r0.addr = '0; r0.data = '0;
        r1.valid = 0; r1.addr = '0; r1.data = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ncs, sclk, copi, busy, done, r0.ready, r0.err, r1.ready, r1.err} !== 9'b100000000)
            begin errors++; $display("FAIL reset_outputs: got %b required 100000000",
                  {ncs, sclk, copi, busy, done, r0.ready, r0.err, r1.ready, r1.err}); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ncs, sclk, busy, done} !== 4'b1000)
            begin errors++; $display("FAIL idle_after_reset: got %b required 1000", {ncs, sclk, busy, done}); end
    endtask

    task automatic test_single_frame();
        logic [6:0] a; logic [7:0] d; logic [15:0] bits; int edges, low, first, last;
        for (int k = 0; k < 4; k++) begin
            a = (k == 0) ? 7'd4 : 7'($urandom_range(0, MAX_ADDR));
            d = (k == 0) ? 8'hA5 : 8'($urandom);
            clr();
            issue(0, a, d);
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b required 1", busy); end
            wait_done();
            checks++;
            if (gnt_id.size() != 1 || gnt_id[0] != 0 || gnt_err[0] != 0)
                begin errors++; $display("FAIL single_grant: got %0d grants required one clean req0 grant", gnt_id.size()); end
            pop_frame(bits, edges, low, first, last);
            checks++;
            if (bits !== {1'b1, a, d}) begin errors++; $display("FAIL single_frame: got %h required %h", bits, {1'b1, a, d}); end
            checks++;
            if (edges != 16 || low != LOW_CYC)
                begin errors++; $display("FAIL single_timing: got edges=%0d low=%0d required 16 %0d", edges, low, LOW_CYC); end
            checks++;
            if (gnt_cyc.size() != 1 || first != gnt_cyc[0] + 1)
                begin errors++; $display("FAIL single_setup_latency: got ncs-low cycle %0d required accept+1", first); end
            checks++;
            if (done_cyc.size() != 1 || done_cyc[0] - last != GAP_CYC)
                begin errors++; $display("FAIL single_gap: got %0d done pulses required one %0d cycles after nCS low", done_cyc.size(), GAP_CYC); end
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_clear: got %b required 0", busy); end
        end
    endtask

    task automatic test_both_valid();
        int id; logic [15:0] bits; int edges, low, first, last;
        pulse_reset();
        clr();
        @(posedge clk); #1;
        r0.valid = 1; r0.addr = 7'd0; r0.data = 8'h11;
        r1.valid = 1; r1.addr = 7'd1; r1.data = 8'h22;
        wait_grant(id);
        checks++;
        if (id != 0) begin errors++; $display("FAIL both_first_grant: got req%0d required req0", id); end
        @(posedge clk); #1 r0.valid = 0;
        wait_grant(id);
        checks++;
        if (id != 1) begin errors++; $display("FAIL both_second_grant: got req%0d required req1", id); end
        @(posedge clk); #1 r1.valid = 0;
        wait_done();
        pop_frame(bits, edges, low, first, last);
        checks++;
        if (bits !== 16'h8011) begin errors++; $display("FAIL both_frame0: got %h required 8011", bits); end
        pop_frame(bits, edges, low, first, last);
        checks++;
        if (bits !== 16'h8122) begin errors++; $display("FAIL both_frame1: got %h required 8122", bits); end
        checks++;
        if (gnt_cyc.size() != 2 || done_cyc.size() != 2 || gnt_cyc[1] - done_cyc[0] != 1)
            begin errors++; $display("FAIL both_idle_gap: got %0d grants %0d dones required second ready one cycle after done", gnt_cyc.size(), done_cyc.size()); end
    endtask

    task automatic test_round_robin();
        int id, last_m; logic [15:0] exp_q[$]; logic [15:0] bits; int edges, low, first, last;
        pulse_reset();
        clr();
        last_m = 1;
        @(posedge clk); #1;
        r0.valid = 1; r0.addr = 7'($urandom_range(0, MAX_ADDR)); r0.data = 8'($urandom);
        r1.valid = 1; r1.addr = 7'($urandom_range(0, MAX_ADDR)); r1.data = 8'($urandom);
        for (int k = 0; k < 4; k++) begin
            wait_grant(id);
            checks++;
            if (id != 1 - last_m) begin errors++; $display("FAIL rr_grant%0d: got req%0d required req%0d", k, id, 1 - last_m); end
            last_m = 1 - last_m;
            if (id == 1) exp_q.push_back({1'b1, r1.addr, r1.data});
            else         exp_q.push_back({1'b1, r0.addr, r0.data});
            @(posedge clk); #1;
            if (k == 3) begin r0.valid = 0; r1.valid = 0; end
            else if (id == 1) begin r1.addr = 7'($urandom_range(0, MAX_ADDR)); r1.data = 8'($urandom); end
            else begin r0.addr = 7'($urandom_range(0, MAX_ADDR)); r0.data = 8'($urandom); end
        end
        wait_done();
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (fr_bits.size() != 4 || gnt_id.size() != 4)
            begin errors++; $display("FAIL rr_count: got %0d frames %0d grants required 4 4", fr_bits.size(), gnt_id.size()); end
        for (int k = 0; k < 4; k++) begin
            pop_frame(bits, edges, low, first, last);
            checks++;
            if (bits !== exp_q[k]) begin errors++; $display("FAIL rr_frame%0d: got %h required %h", k, bits, exp_q[k]); end
        end
    endtask

    task automatic test_err();
        logic [6:0] a; logic [7:0] d; bit bad = 0; logic [15:0] bits; int edges, low, first, last;
        clr();
        issue(1, 7'($urandom_range(MAX_ADDR + 1, 127)), 8'hFF);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || ncs !== 1'b1) bad = 1;
        end
        #1;
        checks++;
        if (gnt_id.size() != 1 || gnt_id[0] != 1 || gnt_err[0] != 1)
            begin errors++; $display("FAIL err_pulse: got %0d grants required one req1 grant with err", gnt_id.size()); end
        checks++;
        if (bad || fr_bits.size() != 0 || done_cyc.size() != 0)
            begin errors++; $display("FAIL err_no_frame: got busy/ncs activity=%0d frames=%0d required 0 0", bad, fr_bits.size()); end
        clr();
        a = 7'($urandom_range(0, MAX_ADDR)); d = 8'($urandom);
        issue(0, a, d);
        wait_done();
        pop_frame(bits, edges, low, first, last);
        checks++;
        if (bits !== {1'b1, a, d} || gnt_err.size() != 1 || gnt_err[0] != 0)
            begin errors++; $display("FAIL err_recover: got %h required %h without err", bits, {1'b1, a, d}); end
    endtask

    task automatic test_reset_mid_frame();
        logic [6:0] a; logic [7:0] d; bit got = 0; logic [15:0] bits; int edges, low, first, last;
        clr();
        issue(1, 7'($urandom_range(0, MAX_ADDR)), 8'($urandom));
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk); #1;
            if (mon_edges == 7) got = 1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL midrst_edge7: got no 7th rising edge required one"); end
        rst = 1'b1;
        #1;
        checks++;
        if ({ncs, sclk, copi, busy} !== 4'b1000)
            begin errors++; $display("FAIL midrst_outputs: got %b required 1000", {ncs, sclk, copi, busy}); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if (done_cyc.size() != 0 || fr_bits.size() != 0)
            begin errors++; $display("FAIL midrst_no_done: got %0d dones %0d frames required 0 0", done_cyc.size(), fr_bits.size()); end
        clr();
        a = 7'($urandom_range(0, MAX_ADDR)); d = 8'($urandom);
        issue(0, a, d);
        wait_done();
        pop_frame(bits, edges, low, first, last);
        checks++;
        if (bits !== {1'b1, a, d} || edges != 16)
            begin errors++; $display("FAIL midrst_refresh: got %h edges=%0d required %h 16", bits, edges, {1'b1, a, d}); end
    endtask

    task automatic test_gap_request();
        logic [6:0] a, a1; logic [7:0] d, d1; int id; bit got = 0; logic [15:0] bits; int edges, low, first, last;
        clr();
        a = 7'($urandom_range(0, MAX_ADDR)); d = 8'($urandom);
        a1 = 7'($urandom_range(0, MAX_ADDR)); d1 = 8'($urandom);
        issue(0, a, d);
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge clk);
            if (ncs) got = 1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL gap_wait: got no nCS rise required one"); end
        @(posedge clk); #1;
        r1.valid = 1; r1.addr = a1; r1.data = d1;
        wait_grant(id);
        @(posedge clk); #1;
        r1.valid = 0; r1.addr = ~a1; r1.data = ~d1;
        wait_done();
        checks++;
        if (gnt_cyc.size() != 2 || done_cyc.size() < 1 || gnt_cyc[1] != done_cyc[0] + 1)
            begin errors++; $display("FAIL gap_ready_timing: got %0d grants required req1 ready one cycle after done", gnt_cyc.size()); end
        pop_frame(bits, edges, low, first, last);
        pop_frame(bits, edges, low, first, last);
        checks++;
        if (bits !== {1'b1, a1, d1}) begin errors++; $display("FAIL gap_latched: got %h required %h", bits, {1'b1, a1, d1}); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_both_valid();
        test_round_robin();
        test_err();
        test_reset_mid_frame();
        test_gap_request();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
